// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants and the transmitter state encoding.
package arp_pkg;

  localparam int          ARP_HDR_LEN     = 28;
  localparam int          ETH_MIN_PAYLOAD = 46;
  localparam logic [7:0]  ARP_HLEN_ETH    = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4   = 8'd4;
  localparam logic [15:0] ETHTYPE_ARP     = 16'h0806;
  localparam logic [15:0] HTYPE_ETH       = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4      = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN
  } tx_state_e;

endpackage

// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: latches parallel ARP fields and emits an Ethernet
// header plus the big-endian ARP body (optionally zero padded) on AXI stream.
module arp_eth_tx
  import arp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int PAD_ENABLE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy
);

  localparam int LEN   = (PAD_ENABLE != 0) ? ETH_MIN_PAYLOAD : ARP_HDR_LEN;
  localparam int WORDS = (LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PTR_W = 6;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

  tx_state_e                 state, state_next;
  logic                      frame_ready;
  logic                      hdr_valid;
  logic                      pay_valid;
  logic [PTR_W-1:0]          ptr;
  logic [ARP_HDR_LEN*8-1:0]  body;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [KEEP_WIDTH-1:0]     keep;
  logic                      tlast;
  logic                      accept;
  logic                      hdr_done;
  logic                      last_done;

  // Byte n of the ARP body, counted from the first byte on the wire; pad is zero.
  function automatic logic [7:0] arp_byte(input logic [ARP_HDR_LEN*8-1:0] b, input int n);
    if (n >= ARP_HDR_LEN) return 8'h00;
    return b[(ARP_HDR_LEN - 1 - n) * 8 +: 8];
  endfunction

  assign accept    = s_frame_valid && frame_ready;
  assign hdr_done  = hdr_valid && m_eth_hdr_ready;
  assign tlast     = pay_valid && (ptr == LAST_PTR);
  assign last_done = tlast && m_eth_payload_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SEND;
      ST_SEND:  if (last_done) state_next = (hdr_done || !hdr_valid) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (hdr_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ready    <= 1'b0;
      hdr_valid      <= 1'b0;
      pay_valid      <= 1'b0;
      ptr            <= '0;
      m_eth_dest_mac <= '0;
      m_eth_src_mac  <= '0;
      m_eth_type     <= '0;
      body           <= '0;
    end else begin
      // Ready only after a full cycle spent in IDLE, which enforces the inter-frame gap.
      frame_ready <= (state == ST_IDLE) && !accept;
      if (accept) begin
        m_eth_dest_mac <= s_eth_dest_mac;
        m_eth_src_mac  <= s_eth_src_mac;
        m_eth_type     <= s_eth_type;
        body           <= {s_arp_htype, s_arp_ptype, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                           s_arp_oper, s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};
        hdr_valid      <= 1'b1;
        pay_valid      <= 1'b1;
        ptr            <= '0;
      end else begin
        if (hdr_done) hdr_valid <= 1'b0;
        if (pay_valid && m_eth_payload_axis_tready) begin
          if (tlast) pay_valid <= 1'b0;
          else       ptr <= ptr + 1'b1;
        end
      end
    end
  end

  // Word lanes derive purely from ptr and the latched body, so they hold through stalls.
  always_comb begin
    tdata = '0;
    keep  = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (pay_valid && (int'(ptr) * KEEP_WIDTH + i) < LEN) begin
        tdata[i*8 +: 8] = arp_byte(body, int'(ptr) * KEEP_WIDTH + i);
        keep[i]         = 1'b1;
      end
    end
  end

  assign s_frame_ready             = frame_ready;
  assign m_eth_hdr_valid           = hdr_valid;
  assign m_eth_payload_axis_tdata  = tdata;
  assign m_eth_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? keep : '1;
  assign m_eth_payload_axis_tvalid = pay_valid;
  assign m_eth_payload_axis_tlast  = tlast;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = (state != ST_IDLE);

endmodule

// File: tb/tb_arp_eth_tx.sv
// Bench for arp_eth_tx: three widths (8/no pad, 32/pad, 64/pad) against a
// frame-level reference model of the byte stream and handshakes.
module tb_arp_eth_tx;
  import arp_pkg::*;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tready;
  logic       hdr_ready;
  logic [2:0] fv;
  frame_t     fld [3];

  wire  [2:0] rdy, hv, tv, tl, tu, bsy;
  wire [47:0] hd_a [3];
  wire [47:0] hs_a [3];
  wire [15:0] ht_a [3];
  wire [63:0] td_a [3];
  wire  [7:0] tk_a [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW  = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    localparam int PAD = (g == 0) ? 0 : 1;
    logic [DW-1:0]   td;
    logic [DW/8-1:0] tk;
    arp_eth_tx #(.DATA_WIDTH(DW), .KEEP_WIDTH(DW/8), .PAD_ENABLE(PAD)) u_dut (
      .clk(clk), .rst(rst),
      .s_frame_valid(fv[g]), .s_frame_ready(rdy[g]),
      .s_eth_dest_mac(fld[g].dest), .s_eth_src_mac(fld[g].src), .s_eth_type(fld[g].etype),
      .s_arp_htype(fld[g].htype), .s_arp_ptype(fld[g].ptype), .s_arp_oper(fld[g].oper),
      .s_arp_sha(fld[g].sha), .s_arp_spa(fld[g].spa), .s_arp_tha(fld[g].tha), .s_arp_tpa(fld[g].tpa),
      .m_eth_hdr_valid(hv[g]), .m_eth_hdr_ready(hdr_ready),
      .m_eth_dest_mac(hd_a[g]), .m_eth_src_mac(hs_a[g]), .m_eth_type(ht_a[g]),
      .m_eth_payload_axis_tdata(td), .m_eth_payload_axis_tkeep(tk),
      .m_eth_payload_axis_tvalid(tv[g]), .m_eth_payload_axis_tready(tready),
      .m_eth_payload_axis_tlast(tl[g]), .m_eth_payload_axis_tuser(tu[g]),
      .busy(bsy[g])
    );
    assign td_a[g] = 64'(td);
    assign tk_a[g] = 8'(tk);
  end

  function automatic int kw(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
  endfunction
  function automatic int plen(input int g);
    return (g == 0) ? 28 : 46;
  endfunction

  // Wire byte n of a frame from field arithmetic: htype ptype hlen plen oper sha spa tha tpa, then zeros.
  function automatic logic [7:0] ebyte(input frame_t f, input int n);
    if (n < 2)  return 8'(f.htype >> (8 * (1 - n)));
    if (n < 4)  return 8'(f.ptype >> (8 * (3 - n)));
    if (n == 4) return 8'd6;
    if (n == 5) return 8'd4;
    if (n < 8)  return 8'(f.oper >> (8 * (7 - n)));
    if (n < 14) return 8'(f.sha >> (8 * (13 - n)));
    if (n < 18) return 8'(f.spa >> (8 * (17 - n)));
    if (n < 24) return 8'(f.tha >> (8 * (23 - n)));
    if (n < 28) return 8'(f.tpa >> (8 * (27 - n)));
    return 8'h00;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.dest  = 48'({$urandom, $urandom});
    f.src   = 48'({$urandom, $urandom});
    f.etype = 16'($urandom);
    f.htype = 16'($urandom);
    f.ptype = 16'($urandom);
    f.oper  = 16'($urandom);
    f.sha   = 48'({$urandom, $urandom});
    f.spa   = $urandom;
    f.tha   = 48'({$urandom, $urandom});
    f.tpa   = $urandom;
    return f;
  endfunction

  function automatic frame_t dir_frame();
    frame_t f;
    f.dest  = 48'hFFFF_FFFF_FFFF;
    f.src   = 48'h5A51_5253_5455;
    f.etype = ETHTYPE_ARP;
    f.htype = HTYPE_ETH;
    f.ptype = PTYPE_IPV4;
    f.oper  = 16'd2;
    f.sha   = 48'h5A51_5253_5455;
    f.spa   = 32'hC0A8_0164;
    f.tha   = 48'hDAD1_D2D3_D4D5;
    f.tpa   = 32'hC0A8_0180;
    return f;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", tag, g, act, exp);
    end
  endtask

  // Reference model state per instance.
  logic       open [3] = '{0, 0, 0};
  logic       hp   [3] = '{0, 0, 0};
  logic       pp   [3] = '{0, 0, 0};
  int         wd   [3] = '{0, 0, 0};
  int         gap  [3] = '{0, 0, 0};
  int         tl_cnt [3] = '{0, 0, 0};
  int         nexp [3] = '{0, 0, 0};
  frame_t     ef   [3];
  logic [2:0] tmo = '0;
  logic       fin = 1'b0;
  int         cyc = 0;
  logic       erdy, elast;
  logic [63:0] edata;
  logic [7:0]  ekeep;
  int          nb;

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        chk("rst_ready", g, 64'(rdy[g]), 64'd0);
        chk("rst_hdr_valid", g, 64'(hv[g]), 64'd0);
        chk("rst_tvalid", g, 64'(tv[g]), 64'd0);
        chk("rst_tlast", g, 64'(tl[g]), 64'd0);
        chk("rst_busy", g, 64'(bsy[g]), 64'd0);
        chk("rst_tdata", g, td_a[g], 64'd0);
        chk("rst_tkeep", g, 64'(tk_a[g]), (g == 0) ? 64'd1 : 64'd0);
        chk("rst_dest", g, 64'(hd_a[g]), 64'd0);
        open[g] = 1'b0; hp[g] = 1'b0; pp[g] = 1'b0; gap[g] = 0;
      end else begin
        if (!open[g] && gap[g] < 2) gap[g]++;
        erdy  = !open[g] && (gap[g] >= 2);
        elast = ((wd[g] + 1) * kw(g)) >= plen(g);
        chk("ready", g, 64'(rdy[g]), 64'(erdy));
        chk("busy", g, 64'(bsy[g]), 64'(open[g]));
        chk("hdr_valid", g, 64'(hv[g]), 64'(hp[g]));
        chk("tvalid", g, 64'(tv[g]), 64'(pp[g]));
        chk("tuser", g, 64'(tu[g]), 64'd0);
        if (hp[g]) begin
          chk("dest_mac", g, 64'(hd_a[g]), 64'(ef[g].dest));
          chk("src_mac", g, 64'(hs_a[g]), 64'(ef[g].src));
          chk("eth_type", g, 64'(ht_a[g]), 64'(ef[g].etype));
        end
        if (pp[g]) begin
          edata = '0;
          ekeep = '0;
          for (int i = 0; i < kw(g); i++) begin
            nb = wd[g] * kw(g) + i;
            if (nb < plen(g)) begin
              edata[8*i +: 8] = ebyte(ef[g], nb);
              ekeep[i] = 1'b1;
            end
          end
          if (g == 0) ekeep = 8'h01;
          chk("tdata", g, td_a[g], edata);
          chk("tkeep", g, 64'(tk_a[g]), 64'(ekeep));
          chk("tlast", g, 64'(tl[g]), 64'(elast));
          if (g == 2 && wd[g] == 0 && ef[g].htype == 16'h0001 && ef[g].ptype == 16'h0800 && ef[g].oper == 16'h0002)
            chk("word0_const", g, td_a[g], 64'h0200_0406_0008_0100);
          if (g == 2 && elast) chk("last_keep_const", g, 64'(tk_a[g]), 64'h3F);
        end else begin
          chk("idle_tlast", g, 64'(tl[g]), 64'd0);
        end
        if (tv[g] && tready && tl[g]) tl_cnt[g]++;
        if (hp[g] && hdr_ready) hp[g] = 1'b0;
        if (pp[g] && tready) begin
          if (elast) pp[g] = 1'b0;
          else       wd[g]++;
        end
        if (open[g] && !hp[g] && !pp[g]) begin
          open[g] = 1'b0;
          gap[g]  = 0;
        end
        if (fv[g] && erdy) begin
          open[g] = 1'b1; hp[g] = 1'b1; pp[g] = 1'b1; wd[g] = 0;
          ef[g] = fld[g];
        end
      end
    end
    if (fin || cyc > 60000) begin
      if (!fin) chk("watchdog", 0, 64'd1, 64'd0);
      for (int g = 0; g < 3; g++) begin
        chk("tlast_count", g, 64'(tl_cnt[g]), 64'(nexp[g]));
        chk("timeout", g, 64'(tmo[g]), 64'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic send(input int g, input frame_t f, input bit hold);
    int t;
    fld[g] = f;
    fv[g]  = 1'b1;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (rdy[g] && !rst) break;
    end
    if (t == 3000) tmo[g] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) fv[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!bsy[g]) break;
    end
    if (t == 3000) tmo[g] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int g, input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      send(g, rnd ? rand_frame() : dir_frame(), 1'b0);
      wait_done(g);
      nexp[g]++;
    end
  endtask

  task automatic b2b(input int g);
    send(g, rand_frame(), 1'b1);
    send(g, rand_frame(), 1'b0);
    wait_done(g);
    nexp[g] += 2;
  endtask

  logic stall_on = 1'b0;

  initial begin
    rst = 1'b1; fv = '0; tready = 1'b1; hdr_ready = 1'b1;
    for (int g = 0; g < 3; g++) fld[g] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Directed frame, readies held high.
    fork frames(0, 1, 1'b0); frames(1, 1, 1'b0); frames(2, 1, 1'b0); join
    // Header held off for 40 cycles while payload drains.
    fork
      frames(0, 1, 1'b0); frames(1, 1, 1'b0); frames(2, 1, 1'b0);
      begin hdr_ready = 1'b0; repeat (40) @(posedge clk); #1 hdr_ready = 1'b1; end
    join
    // Random frames under random stalls on both handshakes.
    stall_on = 1'b1;
    fork
      begin
        while (stall_on) begin
          @(posedge clk);
          #1;
          tready    = 1'($urandom % 2);
          hdr_ready = 1'($urandom % 2);
        end
      end
    join_none
    fork frames(0, 5, 1'b1); frames(1, 5, 1'b1); frames(2, 5, 1'b1); join
    stall_on = 1'b0;
    @(posedge clk);
    #2 tready = 1'b1; hdr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // Asynchronous reset on payload word 3.
    fork send(0, rand_frame(), 1'b0); send(1, rand_frame(), 1'b0); send(2, rand_frame(), 1'b0); join
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork frames(0, 1, 1'b1); frames(1, 1, 1'b1); frames(2, 1, 1'b1); join
    // Back-to-back frames with valid held high.
    fork b2b(0); b2b(1); b2b(2); join
    repeat (5) @(posedge clk);
    #1 fin = 1'b1;
  end

endmodule

// File: doc/arp_eth_tx.md
Name: arp_eth_tx

Overview:
- ARP frame transmitter: accepts a parsed ARP frame as parallel fields and emits an Ethernet frame.
- Output is an Ethernet header (parallel fields) plus the 28-byte ARP body on an AXI stream.
- Sits between the ARP request/reply logic and the Ethernet MAC-side framer.
- Mirror of the ARP receive path; optional zero padding to the 46-byte Ethernet minimum payload.

Parameters:
- DATA_WIDTH, 8, payload tdata width in bits; must equal KEEP_WIDTH*8.
- KEEP_ENABLE, (DATA_WIDTH>8), drive tkeep; when 0, tkeep is tied all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), bytes per payload word.
- PAD_ENABLE, 1, when 1 append 18 zero bytes so the payload is 46 bytes; when 0 the payload is 28 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_frame_valid  in  1  ARP frame fields valid
- s_frame_ready  out  1  ARP frame accepted
- s_eth_dest_mac  in  48  Ethernet destination MAC
- s_eth_src_mac  in  48  Ethernet source MAC
- s_eth_type  in  16  Ethernet type (0x0806 expected, passed through)
- s_arp_htype  in  16  hardware type
- s_arp_ptype  in  16  protocol type
- s_arp_oper  in  16  operation
- s_arp_sha  in  48  sender MAC
- s_arp_spa  in  32  sender IP
- s_arp_tha  in  48  target MAC
- s_arp_tpa  in  32  target IP
- m_eth_hdr_valid  out  1  Ethernet header valid
- m_eth_hdr_ready  in  1  Ethernet header accepted
- m_eth_dest_mac, m_eth_src_mac  out  48  header MACs
- m_eth_type  out  16  header type
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload data
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload accepted
- m_eth_payload_axis_tlast  out  1  last payload word
- m_eth_payload_axis_tuser  out  1  error flag; always 0
- busy  out  1  frame in progress

Behaviour:
- Reset values: all outputs 0; tkeep is 0 when KEEP_ENABLE, else all-ones; internal state IDLE, ptr 0.
- Reset is async; a reset mid-frame aborts the frame with no tlast emitted.
- s_frame_ready is registered: 1 from the first clock after reset release while in IDLE.
- Accept on s_frame_valid && s_frame_ready:
  - Latch all input fields; hlen is forced to 6 and plen to 4.
  - Next cycle: m_eth_hdr_valid=1 with the latched header, m_eth_payload_axis_tvalid=1 with word 0, busy=1, s_frame_ready=0.
  - Latency from input handshake to first output valid is 1 cycle.
- Byte order on the wire, big-endian per field: htype, ptype, hlen, plen, oper, sha, spa, tha, tpa (28 bytes), then 18 zero bytes when PAD_ENABLE.
- LEN = 46 when PAD_ENABLE, else 28. Byte n goes to word n/KEEP_WIDTH, lane n%KEEP_WIDTH.
- Header and payload handshakes are independent:
  - m_eth_hdr_valid drops the cycle after m_eth_hdr_ready is sampled high.
  - Payload words may complete before, during, or after the header handshake.
- Payload stream:
  - ptr counts words; it advances only on tvalid && tready.
  - tdata, tkeep and tlast are held stable while tvalid && !tready.
  - tlast=1 on word ceil(LEN/KEEP_WIDTH)-1.
  - tkeep is all-ones except the last word, which enables only the low LEN%KEEP_WIDTH lanes (all-ones if that remainder is 0). Unused lanes carry 0.
- States:
  - IDLE -> SEND on accept.
  - SEND -> DRAIN when the tlast word is accepted but the header is still pending.
  - SEND or DRAIN -> IDLE once both the header and the tlast word are done.
  - s_frame_ready returns to 1 the cycle after IDLE is re-entered.
- Simultaneous header and tlast handshake in the same cycle: go directly to IDLE.
- busy=1 from the cycle after accept until the cycle after the frame completes.
- Back-to-back frames: minimum gap is 1 idle cycle between the tlast handshake and the next s_frame_ready.

Decomposition:
- Shared package arp_pkg: ARP_HDR_LEN=28, ETH_MIN_PAYLOAD=46, ARP_HLEN_ETH=6, ARP_PLEN_IPV4=4, ETHTYPE_ARP=16'h0806, HTYPE_ETH=1, PTYPE_IPV4=16'h0800.
- No sub-module. A byte-serializer function (byte index -> field byte mux) lives inside the module.

Test Plan:
- DATA_WIDTH=8, PAD_ENABLE=0, oper=2, sha=5A:51:52:53:54:55, spa=C0A80164, tha=DA:D1:D2:D3:D4:D5, tpa=C0A80180, readies held 1 -> 28 bytes 00 01 08 00 06 04 00 02 5A..80, tlast on byte 27, header valid for 1 cycle, s_frame_ready back at 1 two cycles after tlast.
- DATA_WIDTH=64, PAD_ENABLE=1 -> 6 words; word0 tdata=0x0200040600080100; word5 tkeep=0x3F with tlast; bytes 28..45 are zero.
- m_eth_hdr_ready held 0 for 40 cycles, payload tready=1 -> payload completes, FSM waits in DRAIN, busy stays 1, s_frame_ready stays 0 until the header handshake.
- Random tready stalls (50%) on DATA_WIDTH=32 -> tdata, tkeep and tlast stable during stalls; byte stream identical to the unstalled reference.
- rst asserted asynchronously on payload word 3 -> all outputs 0 immediately; the next frame after release starts at word 0 with the correct bytes.
- Two frames offered back-to-back with s_frame_valid held 1 -> second frame accepted one cycle after IDLE is re-entered, its fields are not corrupted by the first, and tlast count is 2.
